// File: rtl/alu_param_pkg.sv
// rtl/alu_param_pkg.sv - shared op codes, FSM states and Booth recoding patterns for alu_seq_param
package alu_param_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_Y,
    ST_EXEC,
    ST_MUL_ITER,
    ST_DIV_ITER,
    ST_OUT_HI,
    ST_OUT_LO
  } state_t;

  // {Q[1], Q[0], Q[-1]} patterns that select a non-zero Booth digit
  localparam logic [2:0] BOOTH_P1A = 3'b001;  // +M
  localparam logic [2:0] BOOTH_P1B = 3'b010;  // +M
  localparam logic [2:0] BOOTH_P2  = 3'b011;  // +2M
  localparam logic [2:0] BOOTH_N2  = 3'b100;  // -2M
  localparam logic [2:0] BOOTH_N1A = 3'b101;  // -M
  localparam logic [2:0] BOOTH_N1B = 3'b110;  // -M

endpackage

// File: rtl/adder_rca.sv
// rtl/adder_rca.sv - ripple-carry adder with carry-in
module adder_rca #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum
);

  logic [WIDTH-1:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_sum[i] = i_a[i] ^ i_b[i] ^ w_c[i];
    if (i < WIDTH - 1) begin : g_carry
      assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

endmodule

// File: rtl/booth_r4_digit.sv
// rtl/booth_r4_digit.sv - radix-4 Booth recoder: 3 multiplier bits to {sel_M, sel_2M, negate}
module booth_r4_digit (
  input  logic [2:0] i_bits,
  output logic       o_sel_m,
  output logic       o_sel_2m,
  output logic       o_negate
);
  import alu_param_pkg::*;

  // Digit 0 (000, 111) leaves every select low so the adder sees a zero operand
  always_comb begin
    o_sel_m  = 1'b0;
    o_sel_2m = 1'b0;
    o_negate = 1'b0;
    case (i_bits)
      BOOTH_P1A, BOOTH_P1B: o_sel_m = 1'b1;
      BOOTH_P2:             o_sel_2m = 1'b1;
      BOOTH_N2: begin
        o_sel_2m = 1'b1;
        o_negate = 1'b1;
      end
      BOOTH_N1A, BOOTH_N1B: begin
        o_sel_m  = 1'b1;
        o_negate = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - sequential add/sub/Booth-mul/restoring-div ALU; optional ALU_MUL_EARLY_TERM_EN
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BEGIN,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             END,
  output logic             busy,
  output logic             ovf,
  output logic             div_by_zero
);
  import alu_param_pkg::*;

  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_op;
  logic [AW-1:0]     r_a;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  r_m;
  logic              r_q1;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf;
  logic              r_dbz;

  logic [AW-1:0]     w_add_a;
  logic [AW-1:0]     w_add_b;
  logic              w_add_cin;
  logic [AW-1:0]     w_sum;
  logic [AW-1:0]     w_m_ext;
  logic [WIDTH:0]    w_div_a;
  logic              w_sel_m;
  logic              w_sel_2m;
  logic              w_neg;
  logic              w_early;
  logic [AW+WIDTH:0] w_mul_step;
  logic [AW+WIDTH:0] w_mul_upd;

  assign w_m_ext    = {{2{r_m[WIDTH-1]}}, r_m};
  assign w_div_a    = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
  // One Booth step: A+digit, then A:Q:Q[-1] arithmetic shift right by 2
  assign w_mul_step = {{2{w_sum[AW-1]}}, w_sum, r_q[WIDTH-1:1]};

  booth_r4_digit u_booth (
    .i_bits   ({r_q[1:0], r_q1}),
    .o_sel_m  (w_sel_m),
    .o_sel_2m (w_sel_2m),
    .o_negate (w_neg)
  );

  adder_rca #(.WIDTH(AW)) u_adder (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_cin (w_add_cin),
    .o_sum (w_sum)
  );

`ifdef ALU_MUL_EARLY_TERM_EN
  // Unconsumed multiplier bits sit in Q[WIDTH-1-2*cnt:0]; if they and Q[-1] agree, all remaining digits are 0
  logic [WIDTH-1:0] w_mask;
  logic [CW:0]      w_rem_sh;
  logic [AW+WIDTH:0] w_shifted;
  assign w_mask    = {WIDTH{1'b1}} >> {r_cnt, 1'b0};
  assign w_early   = ((r_q ^ {WIDTH{r_q1}}) & w_mask) == '0;
  assign w_rem_sh  = (CW+1)'(WIDTH) - {r_cnt, 1'b0};
  assign w_shifted = $signed({r_a, r_q, r_q1}) >>> w_rem_sh;
  assign w_mul_upd = w_early ? w_shifted : w_mul_step;
`else
  assign w_early   = 1'b0;
  assign w_mul_upd = w_mul_step;
`endif

  // Shared adder operand select: add/sub in EXEC, Booth digit in MUL_ITER, trial subtract in DIV_ITER
  always_comb begin
    w_add_a   = r_a;
    w_add_b   = '0;
    w_add_cin = 1'b0;
    case (r_state)
      ST_EXEC: begin
        w_add_a   = {{2{r_q[WIDTH-1]}}, r_q};
        w_add_b   = (r_op == OP_SUB) ? ~w_m_ext : w_m_ext;
        w_add_cin = (r_op == OP_SUB);
      end
      ST_MUL_ITER: begin
        w_add_b   = w_sel_m  ? (w_neg ? ~w_m_ext : w_m_ext) :
                    w_sel_2m ? (w_neg ? ~{w_m_ext[AW-2:0], 1'b0} : {w_m_ext[AW-2:0], 1'b0}) :
                    '0;
        w_add_cin = w_neg;
      end
      ST_DIV_ITER: begin
        w_add_a   = {1'b0, w_div_a};
        w_add_b   = ~{2'b00, r_m};
        w_add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and bus outputs
  always_comb begin
    w_next = r_state;
    outbus = '0;
    END    = 1'b0;
    busy   = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE:     if (BEGIN) w_next = ST_LOAD_Y;
      ST_LOAD_Y:   w_next = (r_op == OP_MUL) ? ST_MUL_ITER : ST_EXEC;
      ST_EXEC: begin
        if (r_op == OP_DIV) w_next = (r_m == '0) ? ST_OUT_HI : ST_DIV_ITER;
        else                w_next = ST_OUT_LO;
      end
      ST_MUL_ITER: if (w_early || r_cnt == MUL_LAST) w_next = ST_OUT_HI;
      ST_DIV_ITER: if (r_cnt == DIV_LAST) w_next = ST_OUT_HI;
      ST_OUT_HI: begin
        outbus = (r_op == OP_MUL) ? r_a[WIDTH-1:0] : r_q;
        w_next = ST_OUT_LO;
      end
      ST_OUT_LO: begin
        outbus = (r_op == OP_DIV) ? r_a[WIDTH-1:0] : r_q;
        END    = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign ovf         = r_ovf;
  assign div_by_zero = r_dbz;

  // Datapath registers: operand capture, iteration steps and sticky flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op  <= '0;
      r_a   <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_q1  <= 1'b0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (BEGIN) begin
          r_op  <= op_code;
          r_q   <= inbus;
          r_a   <= '0;
          r_q1  <= 1'b0;
          r_cnt <= '0;
          r_ovf <= 1'b0;
          r_dbz <= 1'b0;
        end
        ST_LOAD_Y: r_m <= inbus;
        ST_EXEC: begin
          if (r_op == OP_DIV) begin
            if (r_m == '0) begin
              r_q   <= '1;
              r_a   <= {2'b00, r_q};
              r_dbz <= 1'b1;
            end else begin
              r_cnt <= '0;
            end
          end else begin
            r_q   <= w_sum[WIDTH-1:0];
            r_ovf <= w_sum[WIDTH] ^ w_sum[WIDTH-1];
          end
        end
        ST_MUL_ITER: begin
          {r_a, r_q, r_q1} <= w_mul_upd;
          r_cnt            <= r_cnt + 1'b1;
        end
        ST_DIV_ITER: begin
          // Negative trial result restores the shifted A and shifts in a 0 quotient bit
          if (w_sum[AW-1]) begin
            r_a <= {1'b0, w_div_a};
            r_q <= {r_q[WIDTH-2:0], 1'b0};
          end else begin
            r_a <= {1'b0, w_sum[WIDTH:0]};
            r_q <= {r_q[WIDTH-2:0], 1'b1};
          end
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// tb/tb_alu_seq_param.sv - self-checking bench for alu_seq_param (vector table, corner sequences, random vs model)
module tb_alu_seq_param;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         BEGIN;
  logic [1:0]   op_code;
  logic [W-1:0] inbus;
  logic [W-1:0] outbus;
  logic         END;
  logic         busy;
  logic         ovf;
  logic         div_by_zero;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] e_prev;
    logic [W-1:0] e_lo;
    logic         e_ovf;
    logic         e_dbz;
    int           e_end;
  } vec_t;

  vec_t tbl[15];

  alu_seq_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .BEGIN       (BEGIN),
    .op_code     (op_code),
    .inbus       (inbus),
    .outbus      (outbus),
    .END         (END),
    .busy        (busy),
    .ovf         (ovf),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s got %0h expected %0h", tag, what, act, exp);
  endtask

  // Reference results from plain integer arithmetic
  function automatic void model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] e_prev, output logic [W-1:0] e_lo,
                                output logic e_ovf, output logic e_dbz, output int e_end);
    int sx, sy, s;
    longint p;
    logic [2*W-1:0] pv;
    sx = int'($signed(x));
    sy = int'($signed(y));
    e_prev = '0;
    e_lo   = '0;
    e_ovf  = 1'b0;
    e_dbz  = 1'b0;
    e_end  = 3;
    case (op)
      2'b00, 2'b01: begin
        s = (op == 2'b00) ? sx + sy : sx - sy;
        e_lo  = W'(s);
        e_ovf = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
      end
      2'b10: begin
        p      = longint'(sx) * longint'(sy);
        pv     = (2 * W)'(p);
        e_prev = pv[2*W-1:W];
        e_lo   = pv[W-1:0];
        e_end  = W / 2 + 3;
      end
      default: begin
        if (y == '0) begin
          e_prev = '1;
          e_lo   = x;
          e_dbz  = 1'b1;
          e_end  = 4;
        end else begin
          e_prev = x / y;
          e_lo   = x % y;
          e_end  = W + 4;
        end
      end
    endcase
  endfunction

`ifdef ALU_MUL_EARLY_TERM_EN
  // Multiply finishes once the remaining multiplier bits (with the bit below them) are all equal
  function automatic int mul_end(input logic [W-1:0] x);
    int e, v, n, m;
    e = int'({x, 1'b0});
    for (int k = 0; k < W / 2; k++) begin
      v = e >> (2 * k);
      n = W + 1 - 2 * k;
      m = (1 << n) - 1;
      if ((v & m) == 0 || (v & m) == m) return k + 4;
    end
    return W / 2 + 3;
  endfunction
`endif

  // One transaction from cycle 0 (BEGIN) to END, with BEGIN noise while busy
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] e_prev, input logic [W-1:0] e_lo,
                        input logic e_ovf, input logic e_dbz, input int e_end);
    int end_cyc;
    logic [W-1:0] prev_out, last_out;
    logic f_ovf, f_dbz, f_busy;
    end_cyc  = -1;
    prev_out = '0;
    last_out = '0;
    f_ovf    = 1'b0;
    f_dbz    = 1'b0;
    f_busy   = 1'b0;
    @(negedge clk);
    BEGIN   = 1'b1;
    op_code = op;
    inbus   = x;
    @(negedge clk);
    chk(tag, "c1_busy_flags", 32'({busy, ovf, div_by_zero}), 32'b100);
    prev_out = outbus;
    BEGIN    = 1'b0;
    inbus    = y;
    for (int cyc = 2; cyc < 60; cyc++) begin
      @(negedge clk);
      BEGIN   = 1'($urandom_range(0, 1));
      op_code = 2'($urandom);
      inbus   = W'($urandom);
      if (END) begin
        end_cyc  = cyc;
        last_out = outbus;
        f_ovf    = ovf;
        f_dbz    = div_by_zero;
        f_busy   = busy;
        BEGIN    = 1'b1;
        break;
      end
      prev_out = outbus;
    end
    @(negedge clk);
    BEGIN = 1'b0;
    chk(tag, "end_cycle", 32'(end_cyc), 32'(e_end));
    chk(tag, "out_prev", 32'(prev_out), 32'(e_prev));
    chk(tag, "out_lo", 32'(last_out), 32'(e_lo));
    chk(tag, "flags", 32'({f_ovf, f_dbz}), 32'({e_ovf, e_dbz}));
    chk(tag, "busy_at_end", 32'(f_busy), 32'd1);
    chk(tag, "idle_after", 32'({busy, END, outbus}), 32'd0);
  endtask

  initial begin
    logic [1:0]   op;
    logic [W-1:0] x, y, ep, el;
    logic         eo, ed;
    int           ee, n_end;

    tbl[0]  = '{2'b00, 8'd100, 8'd50,  8'h00, 8'h96, 1'b1, 1'b0, 3};
    tbl[1]  = '{2'b01, 8'd5,   8'd7,   8'h00, 8'hFE, 1'b0, 1'b0, 3};
    tbl[2]  = '{2'b10, 8'hFD,  8'd7,   8'hFF, 8'hEB, 1'b0, 1'b0, 7};
    tbl[3]  = '{2'b10, 8'h80,  8'h80,  8'h40, 8'h00, 1'b0, 1'b0, 7};
    tbl[4]  = '{2'b11, 8'd200, 8'd7,   8'h1C, 8'h04, 1'b0, 1'b0, 12};
    tbl[5]  = '{2'b11, 8'h5A,  8'h00,  8'hFF, 8'h5A, 1'b0, 1'b1, 4};
    tbl[6]  = '{2'b01, 8'h80,  8'h01,  8'h00, 8'h7F, 1'b1, 1'b0, 3};
    tbl[7]  = '{2'b00, 8'h7F,  8'h01,  8'h00, 8'h80, 1'b1, 1'b0, 3};
    tbl[8]  = '{2'b00, 8'hFF,  8'h01,  8'h00, 8'h00, 1'b0, 1'b0, 3};
    tbl[9]  = '{2'b10, 8'h7F,  8'h80,  8'hC0, 8'h80, 1'b0, 1'b0, 7};
    tbl[10] = '{2'b11, 8'hFF,  8'hFF,  8'h01, 8'h00, 1'b0, 1'b0, 12};
    tbl[11] = '{2'b11, 8'd5,   8'd9,   8'h00, 8'h05, 1'b0, 1'b0, 12};
    tbl[12] = '{2'b10, 8'h00,  8'h55,  8'h00, 8'h00, 1'b0, 1'b0, 7};
    tbl[13] = '{2'b11, 8'hFF,  8'h01,  8'hFF, 8'h00, 1'b0, 1'b0, 12};
    tbl[14] = '{2'b10, 8'hFF,  8'hFF,  8'h00, 8'h01, 1'b0, 1'b0, 7};

    reset   = 1'b0;
    BEGIN   = 1'b0;
    op_code = 2'b00;
    inbus   = '0;
    repeat (2) @(negedge clk);
    chk("reset", "outputs", 32'({outbus, END, busy, ovf, div_by_zero}), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      ee = tbl[i].e_end;
`ifdef ALU_MUL_EARLY_TERM_EN
      if (tbl[i].op == 2'b10) ee = mul_end(tbl[i].x);
`endif
      run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].x, tbl[i].y,
             tbl[i].e_prev, tbl[i].e_lo, tbl[i].e_ovf, tbl[i].e_dbz, ee);
    end

    // Flags hold through idle and clear when the next BEGIN is accepted
    run_op("dbz_hold", 2'b11, 8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b0, 1'b1, 4);
    repeat (3) @(negedge clk);
    chk("dbz_hold", "idle_flag", 32'(div_by_zero), 32'd1);
    run_op("dbz_clear", 2'b00, 8'd1, 8'd2, 8'h00, 8'h03, 1'b0, 1'b0, 3);
    run_op("ovf_hold", 2'b00, 8'd100, 8'd50, 8'h00, 8'h96, 1'b1, 1'b0, 3);
    repeat (3) @(negedge clk);
    chk("ovf_hold", "idle_flag", 32'(ovf), 32'd1);

    // Reset at cycle 4 of a multiply: outputs drop at once and no END follows
    @(negedge clk);
    BEGIN   = 1'b1;
    op_code = 2'b10;
    inbus   = 8'hFD;
    @(negedge clk);
    BEGIN = 1'b0;
    inbus = 8'd7;
    repeat (3) @(negedge clk);
    chk("mid_reset", "busy_c4", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_reset", "outputs", 32'({outbus, END, busy, ovf, div_by_zero}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    n_end = 0;
    repeat (15) begin
      @(negedge clk);
      if (END) n_end++;
    end
    chk("mid_reset", "no_end", 32'(n_end), 32'd0);

    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      x  = W'($urandom);
      y  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      model(op, x, y, ep, el, eo, ed, ee);
`ifdef ALU_MUL_EARLY_TERM_EN
      if (op == 2'b10) ee = mul_end(x);
`endif
      run_op($sformatf("rnd%0d", i), op, x, y, ep, el, eo, ed, ee);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
